// File: rtl/mult_share_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Imported by the arbiter, the multiplier and the top level.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_e;

    localparam logic REQ0       = 1'b0;
    localparam logic REQ1       = 1'b1;

    localparam logic MODE_CLMUL = 1'b0;
    localparam logic MODE_INT   = 1'b1;

endpackage

// File: rtl/cl_rca_mult.sv
// Combinational configurable array multiplier: integer (ripple-carry accumulate)
// or carry-less GF(2) product of two WIDTH-bit operands.
module cl_rca_mult
    import mult_share_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               carry,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    // Same shifted partial products either way; only the accumulate operator differs.
    always_comb begin
        product = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                if (carry == MODE_INT) begin
                    product = product + (a_ext << i);
                end else begin
                    product = product ^ (a_ext << i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, under contention the one
// that did not win last time wins.
module rr_arb2
    import mult_share_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant
);

    logic last_grant;

    always_comb begin
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = REQ1;
        end else begin
            grant = REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ1;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one cl_rca_mult between two requesters: round-robin accept, one
// compute cycle from registered operands, held response tagged with the ID.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_a,
    input  logic [DATA_WIDTH-1:0]   req0_b,
    input  logic                    req0_carry,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_a,
    input  logic [DATA_WIDTH-1:0]   req1_b,
    input  logic                    req1_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_id,
    output logic                    busy
);

    state_e                  state;
    logic                    grant;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic                    op_carry;
    logic                    op_id;
    logic [2*DATA_WIDTH-1:0] product;

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state == IDLE) && (grant == REQ0) && req0_valid;
    assign req1_ready = (state == IDLE) && (grant == REQ1) && req1_valid;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Fed only from the operand registers so requesters may change inputs after handshake.
    cl_rca_mult #(
        .WIDTH (DATA_WIDTH)
    ) u_mult (
        .a       (op_a),
        .b       (op_b),
        .carry   (op_carry),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_carry  <= MODE_CLMUL;
            op_id     <= REQ0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= REQ0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= (grant == REQ1) ? req1_a : req0_a;
                        op_b     <= (grant == REQ1) ? req1_b : req0_b;
                        op_carry <= (grant == REQ1) ? req1_carry : req0_carry;
                        op_id    <= grant;
                        state    <= COMPUTE;
                        busy     <= 1'b1;
                    end
                end
                COMPUTE: begin
                    rsp_data  <= product;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (DATA_WIDTH = 8) with a transaction-level
// reference model compared every falling edge plus literal checks per scenario.
module tb_mult_share_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_carry = 1'b0, req1_carry = 1'b0;
    logic          rsp_valid, rsp_id, busy;
    logic          rsp_ready = 1'b0;
    logic [2*DW-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_carry (req0_carry),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_carry (req1_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: integer by plain multiply, carry-less by per-bit parity of a_i & b_(k-i).
    function automatic logic [2*DW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                   input logic carry);
        logic [2*DW-1:0] r;
        if (carry) begin
            r = (2*DW)'(a) * (2*DW)'(b);
        end else begin
            r = '0;
            for (int k = 0; k < 2*DW - 1; k++) begin
                logic p;
                p = 1'b0;
                for (int i = 0; i < DW; i++) begin
                    if (k - i >= 0 && k - i < DW) p = p ^ (a[i] & b[k-i]);
                end
                r[k] = p;
            end
        end
        return r;
    endfunction

    // Transaction model: one operation in flight, response visible one edge after accept.
    logic            m_inflight = 1'b0, m_shown = 1'b0, m_last = 1'b1, m_id = 1'b0;
    logic [2*DW-1:0] m_prod = '0, m_data_out = '0;
    logic            m_id_out = 1'b0;

    always @(negedge clk) begin
        logic exp_r0, exp_r1;
        if (!rst_n) begin
            m_inflight = 1'b0; m_shown = 1'b0; m_last = 1'b1;
            m_data_out = '0; m_id_out = 1'b0;
        end
        exp_r0 = !m_inflight && req0_valid && (!req1_valid || m_last == 1'b1);
        exp_r1 = !m_inflight && req1_valid && (!req0_valid || m_last == 1'b0);
        check("req0_ready", req0_ready, exp_r0);
        check("req1_ready", req1_ready, exp_r1);
        check("busy", busy, m_inflight);
        check("rsp_valid", rsp_valid, m_inflight && m_shown);
        check("rsp_data", rsp_data, m_data_out);
        check("rsp_id", rsp_id, m_id_out);
        if (rst_n) begin
            if (!m_inflight) begin
                if (exp_r0 || exp_r1) begin
                    m_inflight = 1'b1;
                    m_shown    = 1'b0;
                    m_id       = exp_r1;
                    m_last     = exp_r1;
                    m_prod     = exp_r1 ? model_prod(req1_a, req1_b, req1_carry)
                                        : model_prod(req0_a, req0_b, req0_carry);
                end
            end else if (!m_shown) begin
                m_shown    = 1'b1;
                m_data_out = m_prod;
                m_id_out   = m_id;
            end else if (rsp_ready) begin
                m_inflight = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic c);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_carry = c;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_carry = c;
        end
    endtask

    task automatic do_op(input string name, input logic id, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic c, input int hold,
                         input logic alter, input logic [2*DW-1:0] exp);
        logic accepted;
        int   waited;
        accepted = 1'b0;
        drive(id, 1'b1, a, b, c);
        for (int k = 0; k < 20 && !accepted; k++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) accepted = 1'b1;
            tick();
        end
        check({name, "_accept"}, accepted, 1'b1);
        drive(id, 1'b0, alter ? DW'(8'h07) : a, b, c);
        waited = 0;
        #1;
        while (rsp_valid !== 1'b1 && waited < 10) begin
            tick();
            #1;
            waited++;
        end
        check({name, "_latency"}, waited, 1);
        check({name, "_data"}, rsp_data, exp);
        check({name, "_id"}, rsp_id, id);
        for (int h = 0; h < hold; h++) begin
            tick();
            #1;
            check({name, "_hold_valid"}, rsp_valid, 1'b1);
            check({name, "_hold_data"}, rsp_data, exp);
            check({name, "_hold_rdy"}, {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check({name, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [1:0]      ids [4];
        logic [2*DW-1:0] datas [4];
        int              got;

        check("model_int_ff", model_prod(8'hFF, 8'hFF, 1'b1), 16'hFE01);
        check("model_clmul_ff", model_prod(8'hFF, 8'hFF, 1'b0), 16'h5555);
        check("model_clmul_33", model_prod(8'h03, 8'h03, 1'b0), 16'h0005);

        tick();
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rsp_data", rsp_data, 16'h0000);
        check("reset_rsp_id", rsp_id, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        do_op("int_3x3",   1'b0, 8'h03, 8'h03, 1'b1, 0, 1'b0, 16'h0009);
        do_op("clmul_3x3", 1'b0, 8'h03, 8'h03, 1'b0, 0, 1'b0, 16'h0005);
        do_op("int_ff",    1'b1, 8'hFF, 8'hFF, 1'b1, 0, 1'b0, 16'hFE01);
        do_op("clmul_ff",  1'b1, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, 16'h5555);
        do_op("int_zero",  1'b0, 8'h00, 8'h5A, 1'b1, 0, 1'b0, 16'h0000);
        do_op("clmul_zero",1'b1, 8'h00, 8'h5A, 1'b0, 0, 1'b0, 16'h0000);
        do_op("backpress", 1'b1, 8'h0C, 8'h0B, 1'b1, 5, 1'b0, 16'h0084);
        do_op("isolation", 1'b0, 8'h05, 8'h02, 1'b1, 0, 1'b1, 16'h000A);

        // Contention from the first cycle after reset, consumer always ready.
        do_reset();
        drive(1'b0, 1'b1, 8'h03, 8'h05, 1'b1);
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                ids[got]   = {1'b0, rsp_id};
                datas[got] = rsp_data;
                got++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("contend_count", got, 4);
        for (int k = 0; k < 4; k++) begin
            check("contend_id", ids[k], (k % 2 == 0) ? 2'd0 : 2'd1);
            check("contend_data", datas[k], (k % 2 == 0) ? 16'h000F : 16'h5555);
        end
        repeat (3) tick();
        rsp_ready = 1'b0;

        // Reset during COMPUTE, then req0 must win the next contention.
        do_reset();
        tick();
        drive(1'b0, 1'b1, 8'h11, 8'h22, 1'b1);
        #1;
        check("rst_mid_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("rst_mid_in_compute", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'h06, 8'h07, 1'b1);
        drive(1'b1, 1'b1, 8'h09, 8'h09, 1'b1);
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                got = 1;
                check("post_rst_id", rsp_id, 1'b0);
                check("post_rst_data", rsp_data, 16'h002A);
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();
        end
        check("post_rst_seen", got, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) tick();
        rsp_ready = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
